// File: rtl/regfile_bypass_sb_if.sv
// Bus bundle for the dual-write register file: read ports, two write ports,
// the issue strobe and the registered busy vector.
interface regfile_bypass_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic [(2**ADDR_W)-1:0]   busy_vec;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           iss_en, iss_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           iss_en, iss_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_bypass_sb.sv
// Two-write, NUM_RD-read register file with same-cycle write bypass and a
// per-register busy scoreboard for the dual-issue hazard unit.
module regfile_bypass_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input logic               clk,
  input logic               rst,
  regfile_bypass_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              wr0Eff, wr1Eff;
  logic [ADDR_W-1:0] rdAddr [NUM_RD];
  logic [NUM_RD-1:0] hit0, hit1, zeroHit;

  // wr1 wins a same-address collision, so wr0 is suppressed outright
  assign wr1Eff = bus.wr1_en && !((ZERO_REG != 0) && (bus.wr1_addr == '0));
  assign wr0Eff = bus.wr0_en && !((ZERO_REG != 0) && (bus.wr0_addr == '0))
                  && !(bus.wr1_en && (bus.wr1_addr == bus.wr0_addr));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      if (wr0Eff) regs_q[bus.wr0_addr] <= bus.wr0_data;
      if (wr1Eff) regs_q[bus.wr1_addr] <= bus.wr1_data;
      busy_q <= busy_d;
    end
  end

  // Issue is applied after the write clears so a new producer keeps ownership
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.wr0_en && (bus.wr0_addr == ADDR_W'(i))) busy_d[i] = 1'b0;
      if (bus.wr1_en && (bus.wr1_addr == ADDR_W'(i))) busy_d[i] = 1'b0;
      if (bus.iss_en && (bus.iss_addr == ADDR_W'(i))) busy_d[i] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    hit0        = '0;
    hit1        = '0;
    zeroHit     = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rdAddr[k]  = bus.rd_addr[k*ADDR_W +: ADDR_W];
      hit1[k]    = bus.wr1_en && (bus.wr1_addr == rdAddr[k]);
      hit0[k]    = bus.wr0_en && (bus.wr0_addr == rdAddr[k]);
      zeroHit[k] = (ZERO_REG != 0) && (rdAddr[k] == '0);
      if (zeroHit[k]) begin
        bus.rd_data[k*DATA_W +: DATA_W] = '0;
        bus.rd_busy[k]                  = 1'b0;
      end else begin
        if (hit1[k])      bus.rd_data[k*DATA_W +: DATA_W] = bus.wr1_data;
        else if (hit0[k]) bus.rd_data[k*DATA_W +: DATA_W] = bus.wr0_data;
        else              bus.rd_data[k*DATA_W +: DATA_W] = regs_q[rdAddr[k]];
        bus.rd_busy[k] = busy_q[rdAddr[k]] & ~(hit0[k] | hit1[k]);
      end
    end
  end

  assign bus.busy_vec = busy_q;
endmodule
